keypad_scanner: RTL and testbench

Scans a 4x4 matrix hex keypad by driving one column low at a time and reading the four row lines. It debounces presses and releases, then emits one pulse per accepted key with its hex code. An optional 32-bit entry register shifts in each accepted digit, so a typed value can be fed straight to the 8-digit display driver. This block is the input-side counterpart of the board's multiplexed display path.

---
 rtl/keypad_scanner.sv | 172 +++++++++++++++++
 tb/tb_keypad_scanner.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, press/release debounce, one pulse per key.
// Define KEYPAD_ENTRY_EN to build the 32-bit digit entry shift register.
module keypad_scanner #(
    parameter int SCAN_BITS    = 17,
    parameter int DEBOUNCE_CNT = 500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  rows,
    output logic [3:0]  cols,
    input  logic        entry_clear,
    output logic        key_valid,
    output logic [3:0]  key_code,
    output logic        key_held,
    output logic [31:0] entry
);

    localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

    localparam logic [1:0] ST_SCAN     = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [1:0] ST_HELD     = 2'd2;
    localparam logic [1:0] ST_RELEASE  = 2'd3;

    logic [3:0]           sync_q, rs_q;
    logic [1:0]           state_q, state_d;
    logic [1:0]           col_q, col_d;
    logic [1:0]           row_q, row_d;
    logic [SCAN_BITS-1:0] dwell_q, dwell_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 key_valid_q, key_valid_d;
    logic [3:0]           key_code_q, key_code_d;
    logic                 key_held_q, key_held_d;
    logic                 row_low;
    logic [1:0]           first_low;

    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'h0: key_lookup = 4'h1;  4'h1: key_lookup = 4'h2;
            4'h2: key_lookup = 4'h3;  4'h3: key_lookup = 4'hA;
            4'h4: key_lookup = 4'h4;  4'h5: key_lookup = 4'h5;
            4'h6: key_lookup = 4'h6;  4'h7: key_lookup = 4'hB;
            4'h8: key_lookup = 4'h7;  4'h9: key_lookup = 4'h8;
            4'hA: key_lookup = 4'h9;  4'hB: key_lookup = 4'hC;
            4'hC: key_lookup = 4'h0;  4'hD: key_lookup = 4'hF;
            4'hE: key_lookup = 4'hE;  default: key_lookup = 4'hD;
        endcase
    endfunction

    assign row_low = ~rs_q[row_q];

    always_comb begin
        if (!rs_q[0])      first_low = 2'd0;
        else if (!rs_q[1]) first_low = 2'd1;
        else if (!rs_q[2]) first_low = 2'd2;
        else               first_low = 2'd3;
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        dwell_d     = dwell_q;
        cnt_d       = cnt_q;
        key_valid_d = 1'b0;
        key_code_d  = key_code_q;
        key_held_d  = key_held_q;
        case (state_q)
            ST_SCAN: begin
                if (dwell_q == '1) begin
                    dwell_d = '0;
                    if (rs_q != 4'hF) begin
                        row_d   = first_low;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end else begin
                        col_d = col_q + 2'd1;
                    end
                end else begin
                    dwell_d = dwell_q + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (!row_low) begin
                    state_d = ST_SCAN;
                    col_d   = col_q + 2'd1;
                    dwell_d = '0;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CNT)) begin
                    // Row stayed low from the capture edge through the full count.
                    key_valid_d = 1'b1;
                    key_code_d  = key_lookup(row_q, col_q);
                    key_held_d  = 1'b1;
                    state_d     = ST_HELD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!row_low) begin
                    cnt_d   = CNT_W'(1);
                    state_d = ST_RELEASE;
                end
            end
            default: begin
                if (row_low) begin
                    state_d = ST_HELD;
                end else if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
                    key_held_d = 1'b0;
                    col_d      = col_q + 2'd1;
                    dwell_d    = '0;
                    state_d    = ST_SCAN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q      <= 4'hF;
            rs_q        <= 4'hF;
            state_q     <= ST_SCAN;
            col_q       <= 2'd0;
            row_q       <= 2'd0;
            dwell_q     <= '0;
            cnt_q       <= '0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'h0;
            key_held_q  <= 1'b0;
        end else begin
            sync_q      <= rows;
            rs_q        <= sync_q;
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            dwell_q     <= dwell_d;
            cnt_q       <= cnt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
            key_held_q  <= key_held_d;
        end
    end

`ifdef KEYPAD_ENTRY_EN
    logic [31:0] entry_q, entry_d;

    // Clear wins over a digit arriving in the same cycle.
    always_comb begin
        entry_d = entry_q;
        if (entry_clear)      entry_d = 32'h0;
        else if (key_valid_q) entry_d = {entry_q[27:0], key_code_q};
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) entry_q <= 32'h0;
        else       entry_q <= entry_d;
    end

    assign entry = entry_q;
`else
    logic unused_entry_clear;
    assign unused_entry_clear = entry_clear;
    assign entry = 32'h0;
`endif

    assign cols      = ~(4'b0001 << col_q);
    assign key_valid = key_valid_q;
    assign key_code  = key_code_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner (SCAN_BITS=2, DEBOUNCE_CNT=4) with a simple keypad model.
module tb_keypad_scanner;

    localparam int SB   = 2;
    localparam int DB   = 4;
    localparam int DWELL = 1 << SB;

    logic        clock;
    logic        reset;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic        entry_clear;
    logic        key_valid;
    logic [3:0]  key_code;
    logic        key_held;
    logic [31:0] entry;

    logic        key_down;
    logic [1:0]  key_r, key_c;

    int checks = 0;
    int errors = 0;
    int vcount = 0;
    logic [3:0]  obs_q[$];
    logic [3:0]  exp_q[$];
    logic [31:0] exp_entry;

    logic [3:0] keymap [0:3][0:3] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'h0, 4'hF, 4'hE, 4'hD}
    };

    keypad_scanner #(.SCAN_BITS(SB), .DEBOUNCE_CNT(DB)) dut (
        .clock(clock), .reset(reset), .rows(rows), .cols(cols),
        .entry_clear(entry_clear), .key_valid(key_valid), .key_code(key_code),
        .key_held(key_held), .entry(entry)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // A pressed key connects its row to its column; rows are pulled high otherwise.
    assign rows = (key_down && (cols[key_c] == 1'b0)) ? ~(4'b0001 << key_r) : 4'hF;

    always @(negedge clock) begin
        if (!reset && key_valid) begin
            vcount++;
            obs_q.push_back(key_code);
        end
    end

    function automatic logic [31:0] model_shift(input logic [31:0] e, input logic [3:0] d);
`ifdef KEYPAD_ENTRY_EN
        return {e[27:0], d};
`else
        return 32'h0 & {e[27:0], d};
`endif
    endfunction

    function automatic logic [3:0] find_key(input logic [3:0] d);
        logic [3:0] rc = 4'h0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keymap[r][c] == d) rc = {2'(r), 2'(c)};
        return rc;
    endfunction

    task automatic press_key(input logic [1:0] r, input logic [1:0] c, input int hold, output bit ok);
        int n = 0;
        key_r = r; key_c = c; key_down = 1'b1;
        exp_q.push_back(keymap[r][c]);
        while (!key_valid && n < 200) begin @(negedge clock); n++; end
        ok = key_valid;
        repeat (hold) @(negedge clock);
        key_down = 1'b0;
        n = 0;
        while (key_held && n < 50) begin @(negedge clock); n++; end
        ok = ok && !key_held;
        repeat (3) @(negedge clock);
    endtask

    task automatic pulse_clear();
        entry_clear = 1'b1;
        @(negedge clock);
        entry_clear = 1'b0;
        exp_entry = 32'h0;
    endtask

    task automatic wait_col_arrival(input int c, output bit ok);
        int n = 0;
        while (cols[c] == 1'b0 && n < 64) begin @(negedge clock); n++; end
        while (cols[c] != 1'b0 && n < 64) begin @(negedge clock); n++; end
        ok = (n < 64);
    endtask

    task automatic test_reset();
        checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL reset_cols got %b want 1110", cols); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", key_valid); end
        checks++; if (key_code !== 4'h0) begin errors++; $display("FAIL reset_code got %h want 0", key_code); end
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL reset_held got %b want 0", key_held); end
        checks++; if (entry !== 32'h0) begin errors++; $display("FAIL reset_entry got %h want 0", entry); end
    endtask

    task automatic test_idle_scan();
        logic [3:0] want;
        reset = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock);
            want = ~(4'b0001 << ((k / DWELL) % 4));
            checks++;
            if (cols !== want) begin errors++; $display("FAIL idle_cols edge %0d got %b want %b", k, cols, want); end
        end
    endtask

    task automatic test_hold_latency();
        bit ok;
        int n = 0;
        int v0 = vcount;
        bit held_ok = 1'b1;
        wait_col_arrival(0, ok);
        key_r = 2'd1; key_c = 2'd1; key_down = 1'b1;
        wait_col_arrival(1, ok);
        while (!key_valid && n < 60) begin @(negedge clock); n++; end
        checks++;
        if (n !== DWELL + DB + 1) begin errors++; $display("FAIL accept_latency got %0d want %0d", n, DWELL + DB + 1); end
        checks++; if (key_code !== 4'h5) begin errors++; $display("FAIL hold_code got %h want 5", key_code); end
        checks++; if (key_held !== 1'b1) begin errors++; $display("FAIL hold_held_rise got %b want 1", key_held); end
        repeat (10) @(negedge clock);
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL hold_pulses got %0d want 1", vcount - v0); end
        key_down = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (key_held !== 1'b1) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL release_early got held=0 want held=1 for 4 high rs cycles"); end
        @(negedge clock);
        checks++; if (key_held !== 1'b0) begin errors++; $display("FAIL release_fall got %b want 0", key_held); end
        checks++; if (cols !== 4'b1011) begin errors++; $display("FAIL release_next_col got %b want 1011", cols); end
        repeat (3) @(negedge clock);
        exp_entry = model_shift(exp_entry, 4'h5);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_short_press();
        bit ok;
        int v0 = vcount;
        int n;
        logic [3:0] cur;
        wait_col_arrival(3, ok);
        repeat ($urandom_range(0, 2)) @(negedge clock);
        key_r = 2'd0; key_c = 2'd3; key_down = 1'b1;
        repeat (2) @(negedge clock);
        key_down = 1'b0;
        repeat (12) @(negedge clock);
        checks++; if (vcount !== v0) begin errors++; $display("FAIL short_press_pulse got %0d want 0", vcount - v0); end
        cur = cols; n = 0;
        while (cols === cur && n < 10) begin @(negedge clock); n++; end
        for (int t = 0; t < 4; t++) begin
            cur = cols; n = 0;
            while (cols === cur && n < 10) begin @(negedge clock); n++; end
            checks++;
            if (n !== DWELL || cols !== {cur[2:0], cur[3]})
                begin errors++; $display("FAIL rotate step %0d got %b after %0d want %b after %0d", t, cols, n, {cur[2:0], cur[3]}, DWELL); end
        end
    endtask

    task automatic test_entry_digits();
        logic [3:0] seq_a [4] = '{4'h1, 4'h2, 4'h3, 4'hA};
        logic [3:0] rc, got, want;
        bit ok;
        int v0;
        pulse_clear();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < ((pass == 0) ? 4 : 9); i++) begin
                want = (pass == 0) ? seq_a[i] : 4'(i + 1);
                rc = find_key(want);
                v0 = vcount;
                press_key(rc[3:2], rc[1:0], $urandom_range(0, 6), ok);
                got = (obs_q.size() != 0) ? obs_q.pop_front() : 4'hX;
                want = exp_q.pop_front();
                checks++;
                if (!ok || vcount - v0 !== 1 || got !== want)
                    begin errors++; $display("FAIL entry_key %h got code %h pulses %0d ok %0d", want, got, vcount - v0, ok); end
                exp_entry = model_shift(exp_entry, want);
            end
            checks++;
            if (entry !== exp_entry) begin errors++; $display("FAIL entry_value pass %0d got %h want %h", pass, entry, exp_entry); end
            pulse_clear();
            @(negedge clock);
            checks++; if (entry !== 32'h0) begin errors++; $display("FAIL entry_clear got %h want 0", entry); end
            obs_q.delete();
        end
    endtask

    task automatic test_random_keys();
        logic [1:0] r, c;
        logic [3:0] got, want;
        bit ok;
        int v0;
        for (int i = 0; i < 8; i++) begin
            r = 2'($urandom_range(0, 3));
            c = 2'($urandom_range(0, 3));
            v0 = vcount;
            press_key(r, c, $urandom_range(0, 8), ok);
            repeat ($urandom_range(0, 5)) @(negedge clock);
            got = (obs_q.size() != 0) ? obs_q.pop_front() : 4'hX;
            want = exp_q.pop_front();
            exp_entry = model_shift(exp_entry, want);
            checks++;
            if (!ok || vcount - v0 !== 1 || got !== want || entry !== exp_entry)
                begin errors++; $display("FAIL random_key r%0d c%0d got code %h entry %h want code %h entry %h", r, c, got, entry, want, exp_entry); end
        end
        obs_q.delete();
    endtask

    task automatic test_bounce_and_clear();
        logic [1:0] r, c;
        logic [3:0] want;
        int n = 0;
        int v0 = vcount;
        bit held_ok = 1'b1;
        r = 2'($urandom_range(0, 3)); c = 2'($urandom_range(0, 3));
        want = keymap[r][c];
        key_r = r; key_c = c; key_down = 1'b1;
        while (!key_valid && n < 200) begin @(negedge clock); n++; end
        exp_entry = model_shift(exp_entry, want);
        repeat (4) @(negedge clock);
        key_down = 1'b0;
        repeat (2) @(negedge clock);
        key_down = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clock);
            if (key_held !== 1'b1) held_ok = 1'b0;
        end
        checks++; if (!held_ok) begin errors++; $display("FAIL bounce_held got 0 want 1"); end
        checks++; if (vcount - v0 !== 1) begin errors++; $display("FAIL bounce_pulses got %0d want 1", vcount - v0); end
        key_down = 1'b0;
        n = 0;
        while (key_held && n < 50) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        checks++; if (entry !== exp_entry) begin errors++; $display("FAIL pre_clear_entry got %h want %h", entry, exp_entry); end

        r = 2'($urandom_range(0, 3)); c = 2'($urandom_range(0, 3));
        want = keymap[r][c];
        key_r = r; key_c = c; key_down = 1'b1;
        n = 0;
        while (!key_valid && n < 200) begin @(negedge clock); n++; end
        entry_clear = 1'b1;
        @(negedge clock);
        entry_clear = 1'b0;
        exp_entry = 32'h0;
        repeat (2) @(negedge clock);
        checks++; if (entry !== exp_entry) begin errors++; $display("FAIL coincident_clear_entry got %h want 0", entry); end
        checks++; if (key_code !== want) begin errors++; $display("FAIL coincident_clear_code got %h want %h", key_code, want); end
        key_down = 1'b0;
        n = 0;
        while (key_held && n < 50) begin @(negedge clock); n++; end
        repeat (3) @(negedge clock);
        obs_q.delete();
    endtask

    task automatic test_reset_mid_debounce();
        bit ok;
        int v0 = vcount;
        logic [3:0] want;
        wait_col_arrival(0, ok);
        key_r = 2'($urandom_range(0, 2)); key_c = 2'd1; key_down = 1'b1;
        wait_col_arrival(1, ok);
        repeat (DWELL + 2) @(negedge clock);
        #1 reset = 1'b1;
        #1;
        checks++; if (cols !== 4'b1110) begin errors++; $display("FAIL mid_reset_cols got %b want 1110", cols); end
        checks++;
        if (key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0 || entry !== 32'h0)
            begin errors++; $display("FAIL mid_reset_outputs got v%b h%b c%h e%h want all 0", key_valid, key_held, key_code, entry); end
        checks++; if (vcount !== v0) begin errors++; $display("FAIL mid_reset_pulse got %0d want 0", vcount - v0); end
        key_down = 1'b0;
        @(negedge clock);
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            want = ~(4'b0001 << ((k / DWELL) % 4));
            checks++;
            if (cols !== want) begin errors++; $display("FAIL restart_cols edge %0d got %b want %b", k, cols, want); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        entry_clear = 1'b0;
        key_down = 1'b0;
        key_r = 2'd0;
        key_c = 2'd0;
        exp_entry = 32'h0;
        repeat (3) @(negedge clock);
        test_reset();
        test_idle_scan();
        test_hold_latency();
        test_short_press();
        test_entry_digits();
        test_random_keys();
        test_bounce_and_clear();
        test_reset_mid_debounce();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
